// File: rtl/sram_data_port.sv
// Data-memory responder: turns one 32-bit load/store into two 16-bit phases on an
// asynchronous SRAM, holding ready low until the access completes.
module sram_data_port #(
    parameter int unsigned BASE_ADDR     = 1024,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    inout  wire  [15:0] sram_dq,
    output logic        sram_we_n
);

    localparam int unsigned CntW = $clog2(ACCESS_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ACCESS_CYCLES - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLow  = 2'd1;
    localparam logic [1:0] StHigh = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [16:0]     word_q, word_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            is_wr_q, is_wr_d;
    logic [31:0]     read_data_q, read_data_d;
    logic [17:0]     sram_addr_q, sram_addr_d;
    logic            we_n_q, we_n_d;

    logic        req;
    logic        last;
    logic        drive;
    logic [16:0] word_in;

    assign req  = rd_en | wr_en;
    assign last = (cnt_q == CntLast);
    // Offset wraps modulo 2^32; only bits 18:2 select the SRAM word.
    assign word_in = 17'((address - BASE_ADDR) >> 2);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        is_wr_d     = is_wr_q;
        read_data_d = read_data_q;
        sram_addr_d = sram_addr_q;
        we_n_d      = we_n_q;
        case (state_q)
            StIdle: begin
                if (req) begin
                    state_d     = StLow;
                    cnt_d       = '0;
                    word_d      = word_in;
                    wdata_d     = write_data;
                    is_wr_d     = wr_en;
                    sram_addr_d = {word_in, 1'b0};
                    we_n_d      = ~wr_en;
                end
            end
            StLow: begin
                if (last) begin
                    state_d     = StHigh;
                    cnt_d       = '0;
                    sram_addr_d = {word_q, 1'b1};
                    if (!is_wr_q) read_data_d[15:0] = sram_dq;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHigh: begin
                if (last) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    we_n_d  = 1'b1;
                    if (!is_wr_q) read_data_d[31:16] = sram_dq;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            word_q      <= '0;
            wdata_q     <= '0;
            is_wr_q     <= 1'b0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            is_wr_q     <= is_wr_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            we_n_q      <= we_n_d;
        end
    end

    // Bus is driven only while a write phase is active; reset drops it immediately.
    assign drive   = is_wr_q && ((state_q == StLow) || (state_q == StHigh));
    assign sram_dq = drive ? ((state_q == StHigh) ? wdata_q[31:16] : wdata_q[15:0]) : 16'hzzzz;

    assign ready     = (state_q == StIdle) ? ~req : (state_q == StDone);
    assign read_data = read_data_q;
    assign sram_addr = sram_addr_q;
    assign sram_we_n = we_n_q;

endmodule

// File: tb/tb_sram_data_port.sv
// Bench for sram_data_port: two instances (2-cycle and 1-cycle phases), each with its own
// SRAM model, checked cycle by cycle against a word-level reference memory.
module tb_sram_data_port;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rd_en, wr_en;
    logic [31:0] address [2];
    logic [31:0] write_data [2];
    logic [31:0] read_data_a, read_data_b;
    logic        ready_a, ready_b;
    logic [17:0] addr_a, addr_b;
    logic        we_n_a, we_n_b;
    wire  [15:0] dq_a, dq_b;

    logic [15:0] mem_a [262144];
    logic [15:0] mem_b [262144];
    bit          mem_ready = 1'b0;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] refm [int];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;

    sram_data_port #(.BASE_ADDR(1024), .ACCESS_CYCLES(2)) u_dut_a (
        .clk(clk), .rst(rst), .rd_en(rd_en[0]), .wr_en(wr_en[0]),
        .address(address[0]), .write_data(write_data[0]), .read_data(read_data_a),
        .ready(ready_a), .sram_addr(addr_a), .sram_dq(dq_a), .sram_we_n(we_n_a)
    );

    sram_data_port #(.BASE_ADDR(1024), .ACCESS_CYCLES(1)) u_dut_b (
        .clk(clk), .rst(rst), .rd_en(rd_en[1]), .wr_en(wr_en[1]),
        .address(address[1]), .write_data(write_data[1]), .read_data(read_data_b),
        .ready(ready_b), .sram_addr(addr_b), .sram_dq(dq_b), .sram_we_n(we_n_b)
    );

    function automatic logic [15:0] finit(int i);
        return 16'((i * 40503) ^ 23130);
    endfunction

    // Asynchronous SRAM models: drive the bus whenever not being written.
    assign dq_a = we_n_a ? mem_a[addr_a] : 16'hzzzz;
    assign dq_b = we_n_b ? mem_b[addr_b] : 16'hzzzz;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 262144; i++) begin
                mem_a[i] <= finit(i);
                mem_b[i] <= finit(i);
            end
            mem_ready <= 1'b1;
        end else begin
            if (!we_n_a) mem_a[addr_a] <= dq_a;
            if (!we_n_b) mem_b[addr_b] <= dq_b;
        end
    end

    function automatic logic [31:0] o_rd(int d);
        return (d == 0) ? read_data_a : read_data_b;
    endfunction
    function automatic logic o_ready(int d);
        return (d == 0) ? ready_a : ready_b;
    endfunction
    function automatic logic [17:0] o_addr(int d);
        return (d == 0) ? addr_a : addr_b;
    endfunction
    function automatic logic o_wen(int d);
        return (d == 0) ? we_n_a : we_n_b;
    endfunction
    function automatic logic [15:0] o_dq(int d);
        return (d == 0) ? dq_a : dq_b;
    endfunction
    function automatic logic [15:0] o_mem(int d, logic [17:0] i);
        return (d == 0) ? mem_a[i] : mem_b[i];
    endfunction

    function automatic logic [31:0] exp_word(int d, logic [16:0] w);
        int key = d * 131072 + int'(w);
        if (refm.exists(key)) return refm[key];
        return {finit(2 * int'(w) + 1), finit(2 * int'(w))};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One access on DUT d, starting in the next cycle, which must be IDLE.
    task automatic access(input int d, input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit hold);
        int          n = (d == 0) ? 2 : 1;
        logic [16:0] w = 17'((addr - 32'd1024) >> 2);
        logic        h;
        logic [31:0] exp;
        @(posedge clk); #1;
        rd_en[d] = rd; wr_en[d] = wr; address[d] = addr; write_data[d] = wdata;
        #1;
        check("c0_ready", 32'(o_ready(d)), 32'd0);
        for (int c = 1; c <= 2 * n + 1; c++) begin
            @(posedge clk); #1;
            if (c == 1 && !hold) begin
                rd_en[d] = 1'b0; wr_en[d] = 1'b0;
                address[d] = $urandom; write_data[d] = $urandom;
            end
            if (c <= 2 * n) begin
                h = (c > n);
                check("ph_addr", 32'(o_addr(d)), {14'd0, w, h});
                check("ph_we_n", 32'(o_wen(d)), 32'(!wr));
                check("ph_ready", 32'(o_ready(d)), 32'd0);
                if (wr) check("ph_dq", 32'(o_dq(d)), 32'(h ? wdata[31:16] : wdata[15:0]));
            end else begin
                check("done_ready", 32'(o_ready(d)), 32'd1);
                check("done_we_n", 32'(o_wen(d)), 32'd1);
                if (wr) begin
                    refm[d * 131072 + int'(w)] = wdata;
                    check("wr_mem", {o_mem(d, {w, 1'b1}), o_mem(d, {w, 1'b0})}, wdata);
                end else begin
                    last_rd[d] = exp_word(d, w);
                end
                check("done_rdata", o_rd(d), last_rd[d]);
            end
        end
    endtask

    task automatic idle_gap(input int d, input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
            check("idle_ready", 32'(o_ready(d)), 32'd1);
        end
    endtask

    task automatic random_run(input int d, input int count);
        int          op;
        logic [31:0] addr;
        for (int i = 0; i < count; i++) begin
            op   = int'($urandom_range(0, 2));
            addr = 32'd1024 + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
            access(d, op != 1, op != 0, addr, $urandom, 1'b0);
            idle_gap(d, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        rst = 1'b0;
        rd_en = '0; wr_en = '0;
        address[0] = '0; address[1] = '0;
        write_data[0] = '0; write_data[1] = '0;
        last_rd[0] = '0; last_rd[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", 32'(o_ready(d)), 32'd1);
            check("rst_rdata", o_rd(d), 32'd0);
            check("rst_addr", 32'(o_addr(d)), 32'd0);
            check("rst_we_n", 32'(o_wen(d)), 32'd1);
        end
        @(negedge clk) rst = 1'b1;

        // Directed write then read-back, 2-cycle phases
        access(0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0);
        check("wr_lo_half", 32'(mem_a[4]), 32'h0000BEEF);
        check("wr_hi_half", 32'(mem_a[5]), 32'h0000DEAD);
        access(0, 1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
        check("readback", read_data_a, 32'hDEADBEEF);

        // rd_en held across DONE: second access starts in the very next cycle
        access(0, 1'b1, 1'b0, 32'd1032, 32'h0, 1'b1);
        access(0, 1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);

        // Both enables set: write wins, read_data untouched
        access(0, 1'b1, 1'b1, 32'd1040, 32'h13579BDF, 1'b0);
        check("both_rdata", read_data_a, 32'hDEADBEEF);
        access(0, 1'b1, 1'b0, 32'd1040, 32'h0, 1'b0);
        check("both_readback", read_data_a, 32'h13579BDF);

        random_run(0, 24);
        access(0, 1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);

        // Reset in the middle of the HIGH phase of a write
        @(posedge clk); #1;
        wr_en[0] = 1'b1; address[0] = 32'd1024 + 32'd1200; write_data[0] = $urandom;
        @(posedge clk); #1;
        wr_en[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_we_n", 32'(we_n_a), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_async_we_n", 32'(we_n_a), 32'd1);
        check("rst_async_dq", 32'(dq_a), 32'(mem_a[0]));
        check("rst_async_rdata", read_data_a, 32'd0);
        check("rst_async_addr", 32'(addr_a), 32'd0);
        check("rst_async_ready", 32'(ready_a), 32'd1);
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        last_rd[0] = '0; last_rd[1] = '0;
        idle_gap(0, 2);
        access(0, 1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);

        // 1-cycle phases and a wrapping address below the base
        access(1, 1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, 1'b0);
        check("wrap_lo", 32'(mem_b[18'h3FFFE]), 32'h0000F00D);
        check("wrap_hi", 32'(mem_b[18'h3FFFF]), 32'h0000CAFE);
        access(1, 1'b1, 1'b0, 32'd1020, 32'h0, 1'b0);
        check("wrap_readback", read_data_b, 32'hCAFEF00D);
        access(1, 1'b1, 1'b0, 32'd1020, 32'h0, 1'b1);
        access(1, 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
        random_run(1, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_data_port.md
# sram_data_port

Memory-side responder for the pipeline's data accesses. It accepts a load or store from the MEM stage, namely the ALU result as the byte address and Val_Rm as the store data. It performs the access as two 16-bit half-word transactions on an external asynchronous SRAM, then hands back 32-bit read data. While an access is in flight it holds `ready` low, and the hazard/freeze logic stalls every pipeline register on that signal.

## Interface
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.
- `ACCESS_CYCLES`, default 2: clock cycles each half-word phase is held (≥1).
- `clk`  in  1  single clock for the block; all state changes on the rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `rd_en`  in  1  load request (MEM stage mem_r_en).
- `wr_en`  in  1  store request (MEM stage mem_w_en).
- `address`  in  32  byte address (ALU result).
- `write_data`  in  32  store data (Val_Rm).
- `read_data`  out  32  load result, registered.
- `ready`  out  1  high = no access pending; pipeline may advance.
- `sram_addr`  out  18  SRAM half-word address, registered.
- `sram_dq`  inout  16  SRAM data bus; tri-stated unless writing.
- `sram_we_n`  out  1  SRAM write strobe, active low, registered.

## Operation
- Offset: `off = address - BASE_ADDR`, 32-bit modulo arithmetic. Word index = `off[18:2]`; `off[1:0]` ignored (word aligned). Addresses below BASE_ADDR wrap; no error flag.
- Half-word address: `sram_addr = {off[18:2], h}`. `h=0` selects the low half (bits 15:0) and `h=1` the high half (bits 31:16).
- Request in IDLE = `rd_en | wr_en`. If both are set, the access is a write.
- On acceptance, latch the address offset, write_data and op type. Input changes after acceptance are ignored.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: on a request, go to LOW with `sram_addr={word,0}` and the counter at 0. Otherwise stay in IDLE.
  - LOW: remain for ACCESS_CYCLES cycles. On the last cycle go to HIGH and set `sram_addr={word,1}`.
  - HIGH: remain for ACCESS_CYCLES cycles, then go to DONE.
  - DONE: stay one cycle, then go to IDLE unconditionally.
- Phase counter width is `$clog2(ACCESS_CYCLES)+1`. It resets to 0 on every phase entry.
- Write: during LOW, `sram_dq = wdata[15:0]` and `sram_we_n=0`. During HIGH, `sram_dq = wdata[31:16]` and `sram_we_n=0`. In all other states `sram_we_n=1` and `sram_dq` is high-Z.
- Read: `sram_we_n=1` and the bus is high-Z throughout.
  - `read_data[15:0]` captures `sram_dq` on the last LOW cycle's edge.
  - `read_data[31:16]` captures `sram_dq` on the last HIGH cycle's edge.
  - read_data holds until the next read overwrites it. Writes never change it.
- `ready` (combinational):
  - IDLE: 1 when there is no request, 0 the same cycle a request appears.
  - LOW, HIGH: 0.
  - DONE: 1.
- Behaviour in DONE:
  - DONE never launches a new access.
  - Back-to-back requests are taken in the following IDLE cycle, where `ready` again drops the same cycle.
- Reset, at any time: go to IDLE with counter 0, `read_data=0`, `sram_addr=0`, `sram_we_n=1`, bus high-Z. An access interrupted mid-way is abandoned and no DONE is produced.

## Timing
- Reset values: `read_data=0`, `sram_addr=0`, `sram_we_n=1`, `sram_dq` high-Z, `ready=1`. Ready is 1 only because the pipeline issues no request during reset.
- Request seen in cycle 0 (IDLE) gives LOW in cycles 1..N, HIGH in cycles N+1..2N and DONE in cycle 2N+1 (N = ACCESS_CYCLES).
- `ready` is 0 for cycles 0..2N and 1 in cycle 2N+1. With N=2 that is 5 stall cycles, with ready returning in cycle 5.
- `read_data` is valid in DONE and stable afterwards.
- `sram_addr` and `sram_we_n` change only on clock edges, so address and strobe switch together at each phase boundary.
- N=1 is legal: total access is 4 cycles, 3 of them with ready low.

## Test plan
- **Reset.** Assert `rst=0` mid-HIGH of a write → same instant `sram_we_n=1`, bus Z. After release: `ready=1`, `read_data=0`, `sram_addr=0`, and no spurious DONE.
- **Write timing.** Write `address=1024+8`, `write_data=0xDEADBEEF`, N=2:
  - cycles 1-2: `sram_addr=4`, `dq=0xBEEF`, `we_n=0`.
  - cycles 3-4: `sram_addr=5`, `dq=0xDEAD`.
  - cycle 5: `ready=1`, `we_n=1`.
- **Read-back.** Read the same address from an SRAM model holding that data → `read_data=0xDEADBEEF` in DONE, with ready low for exactly 5 cycles.
- **Back-to-back.** Keep `rd_en` high across DONE → the second access starts the cycle after DONE, ready drops again in that IDLE cycle, and there is no gap or duplicate access.
- **Both enables.** `rd_en=wr_en=1` → a write is performed and `read_data` is unchanged.
- **Wrap and N=1.** `address=1020` with BASE 1024 → `sram_addr={off[18:2],h}` = 0x3FFFE/0x3FFFF. With ACCESS_CYCLES=1 the total access takes 4 cycles.
